// File: rtl/sa_os_pkg.sv
// sa_os_pkg: shared types and helpers for the sa_os_stream systolic array.
// Holds the job FSM state encoding and the counter width helper used to size
// the reduction, drain and stream-index counters.
package sa_os_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_STREAM = 2'd3
    } state_e;

    // Bits needed for a counter that must represent 0..max_val (never below 1).
    function automatic int cnt_width(input int max_val);
        if (max_val < 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(max_val + 32'sd1);
        end
    endfunction

endpackage

// File: rtl/sa_os_pe.sv
// sa_os_pe: one output-stationary processing element.
// Multiplies the west (A) and north (B) operands when the beat valid is set,
// accumulates into C[i][j], and forwards A/valid east and B south through one
// register per hop. Optional macro SA_OS_SAT_EN selects a saturating
// accumulate; without it the accumulator wraps in two's complement.
module sa_os_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clr_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    input  logic                         v_i,
    output logic signed [DATA_WIDTH-1:0] a_o,
    output logic signed [DATA_WIDTH-1:0] b_o,
    output logic                         v_o,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);

    logic signed [DATA_WIDTH-1:0]   a_r;
    logic signed [DATA_WIDTH-1:0]   b_r;
    logic                           v_r;
    logic signed [ACC_WIDTH-1:0]    acc_r;
    logic signed [2*DATA_WIDTH-1:0] prod_s;
    logic signed [ACC_WIDTH-1:0]    prod_ext_s;
    logic signed [ACC_WIDTH-1:0]    acc_next_s;

    // Full-precision signed product, sign-extended to the accumulator width.
    assign prod_s     = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
    assign prod_ext_s = ACC_WIDTH'(prod_s);

`ifdef SA_OS_SAT_EN
    logic signed [ACC_WIDTH:0] sum_wide_s;

    // Add with one guard bit and clamp to the accumulator range on overflow.
    always_comb begin
        sum_wide_s = {acc_r[ACC_WIDTH-1], acc_r} + {prod_ext_s[ACC_WIDTH-1], prod_ext_s};
        if (sum_wide_s[ACC_WIDTH] != sum_wide_s[ACC_WIDTH-1]) begin
            if (sum_wide_s[ACC_WIDTH]) begin
                acc_next_s = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            end else begin
                acc_next_s = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end
        end else begin
            acc_next_s = sum_wide_s[ACC_WIDTH-1:0];
        end
    end
`else
    assign acc_next_s = acc_r + prod_ext_s;
`endif

    // Forwarding registers and accumulator; only valid beats change C.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_r   <= {DATA_WIDTH{1'b0}};
            b_r   <= {DATA_WIDTH{1'b0}};
            v_r   <= 1'b0;
            acc_r <= {ACC_WIDTH{1'b0}};
        end else begin
            a_r <= a_i;
            b_r <= b_i;
            v_r <= v_i;
            if (clr_i) begin
                acc_r <= {ACC_WIDTH{1'b0}};
            end else if (v_i) begin
                acc_r <= acc_next_s;
            end else begin
                acc_r <= acc_r;
            end
        end
    end

    assign a_o   = a_r;
    assign b_o   = b_r;
    assign v_o   = v_r;
    assign acc_o = acc_r;

endmodule

// File: rtl/sa_os_stream.sv
// sa_os_stream: output-stationary M_ROWS x N_COLS systolic array computing
// C = A x B. Operand beats are accepted in LOAD, skewed per row/column, flushed
// through the array in DRAIN, and C is streamed row-major in STREAM.
// Optional macro SA_OS_SAT_EN enables saturating accumulation in every PE.
module sa_os_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int M_ROWS     = 4,
    parameter int N_COLS     = 4,
    parameter int K_MAX      = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [$clog2(K_MAX+1)-1:0]          k_len_i,
    input  logic [M_ROWS-1:0][DATA_WIDTH-1:0]   a_data_i,
    input  logic [N_COLS-1:0][DATA_WIDTH-1:0]   b_data_i,
    input  logic                                a_valid_i,
    input  logic                                b_valid_i,
    output logic                                in_ready_o,
    output logic [ACC_WIDTH-1:0]                out_data_o,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic                                out_last_o,
    output logic                                busy_o,
    output logic                                done_o
);

    import sa_os_pkg::*;

    localparam int KW        = $clog2(K_MAX + 1);
    localparam int DRAIN_LEN = M_ROWS + N_COLS - 1;
    localparam int DCW       = cnt_width(DRAIN_LEN);
    localparam int RW        = cnt_width(M_ROWS - 1);
    localparam int CW        = cnt_width(N_COLS - 1);

    state_e                 state_r;
    state_e                 state_next_s;
    logic [KW-1:0]          k_len_r;
    logic [KW-1:0]          k_clamped_s;
    logic [KW-1:0]          beat_r;
    logic [DCW-1:0]         drain_r;
    logic [RW-1:0]          row_r;
    logic [CW-1:0]          col_r;
    logic                   issued_all_r;
    logic [ACC_WIDTH-1:0]   out_data_r;
    logic                   out_valid_r;
    logic                   out_last_r;
    logic                   in_ready_r;
    logic                   busy_r;
    logic                   done_r;

    logic                   start_s;
    logic                   fire_s;
    logic                   beat_last_s;
    logic                   drain_last_s;
    logic                   out_fire_s;
    logic                   stream_done_s;
    logic                   load_out_s;

    logic [DATA_WIDTH-1:0]        a_h_s  [M_ROWS][N_COLS];
    logic                         v_h_s  [M_ROWS][N_COLS];
    logic [DATA_WIDTH-1:0]        b_v_s  [M_ROWS][N_COLS];
    logic signed [ACC_WIDTH-1:0]  acc_s  [M_ROWS][N_COLS];

    assign start_s       = (state_r == ST_IDLE) & start_i;
    assign k_clamped_s   = (k_len_i > KW'(K_MAX)) ? KW'(K_MAX) : k_len_i;
    assign fire_s        = (state_r == ST_LOAD) & a_valid_i & b_valid_i;
    assign beat_last_s   = fire_s & (beat_r == (k_len_r - KW'(1'b1)));
    assign drain_last_s  = (drain_r == DCW'(DRAIN_LEN - 1));
    assign out_fire_s    = out_valid_r & out_ready_i;
    assign stream_done_s = out_fire_s & out_last_r;
    assign load_out_s    = (state_r == ST_STREAM) & ~issued_all_r & (~out_valid_r | out_fire_s);

    // Job sequencing: IDLE -> LOAD -> DRAIN -> STREAM -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    if (k_clamped_s == {KW{1'b0}}) begin
                        state_next_s = ST_STREAM;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (beat_last_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (drain_last_s) begin
                    state_next_s = ST_STREAM;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_STREAM: begin
                if (stream_done_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register and status outputs registered from the next state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            in_ready_r <= (state_next_s == ST_LOAD);
            busy_r     <= (state_next_s != ST_IDLE);
            done_r     <= stream_done_s;
        end
    end

    // Reduction length latch, beat counter and drain counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            k_len_r <= {KW{1'b0}};
            beat_r  <= {KW{1'b0}};
            drain_r <= {DCW{1'b0}};
        end else begin
            if (start_s) begin
                k_len_r <= k_clamped_s;
                beat_r  <= {KW{1'b0}};
            end else if (fire_s) begin
                beat_r  <= beat_r + KW'(1'b1);
            end
            if (state_r == ST_DRAIN) begin
                drain_r <= drain_r + DCW'(1'b1);
            end else begin
                drain_r <= {DCW{1'b0}};
            end
        end
    end

    // Row-major result streaming; output regs hold while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_r        <= {RW{1'b0}};
            col_r        <= {CW{1'b0}};
            issued_all_r <= 1'b0;
            out_data_r   <= {ACC_WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
        end else if (start_s) begin
            row_r        <= {RW{1'b0}};
            col_r        <= {CW{1'b0}};
            issued_all_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
        end else if (load_out_s) begin
            out_data_r  <= acc_s[row_r][col_r];
            out_valid_r <= 1'b1;
            out_last_r  <= (row_r == RW'(M_ROWS - 1)) && (col_r == CW'(N_COLS - 1));
            if (col_r == CW'(N_COLS - 1)) begin
                col_r <= {CW{1'b0}};
                if (row_r == RW'(M_ROWS - 1)) begin
                    issued_all_r <= 1'b1;
                end else begin
                    row_r <= row_r + RW'(1'b1);
                end
            end else begin
                col_r <= col_r + CW'(1'b1);
            end
        end else if (out_fire_s) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    // Row skew: row i's A operand and the beat valid are delayed i cycles.
    for (genvar gi = 0; gi < M_ROWS; gi++) begin : g_a_skew
        if (gi == 0) begin : g_direct
            assign a_h_s[gi][0] = a_data_i[gi];
            assign v_h_s[gi][0] = fire_s;
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] a_sk_r [gi];
            logic                  v_sk_r [gi];

            // Shift register of depth gi for this row's operand and valid.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int d = 32'sd0; d < gi; d++) begin
                        a_sk_r[d] <= {DATA_WIDTH{1'b0}};
                        v_sk_r[d] <= 1'b0;
                    end
                end else begin
                    a_sk_r[0] <= a_data_i[gi];
                    v_sk_r[0] <= fire_s;
                    for (int d = 32'sd1; d < gi; d++) begin
                        a_sk_r[d] <= a_sk_r[d-1];
                        v_sk_r[d] <= v_sk_r[d-1];
                    end
                end
            end

            assign a_h_s[gi][0] = a_sk_r[gi-1];
            assign v_h_s[gi][0] = v_sk_r[gi-1];
        end
    end

    // Column skew: column j's B operand is delayed j cycles.
    for (genvar gj = 0; gj < N_COLS; gj++) begin : g_b_skew
        if (gj == 0) begin : g_direct
            assign b_v_s[0][gj] = b_data_i[gj];
        end else begin : g_delay
            logic [DATA_WIDTH-1:0] b_sk_r [gj];

            // Shift register of depth gj for this column's operand.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    for (int d = 32'sd0; d < gj; d++) begin
                        b_sk_r[d] <= {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    b_sk_r[0] <= b_data_i[gj];
                    for (int d = 32'sd1; d < gj; d++) begin
                        b_sk_r[d] <= b_sk_r[d-1];
                    end
                end
            end

            assign b_v_s[0][gj] = b_sk_r[gj-1];
        end
    end

    // PE grid: A/valid flow east, B flows south, one register per hop.
    for (genvar gi = 0; gi < M_ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < N_COLS; gj++) begin : g_col
            logic [DATA_WIDTH-1:0] a_o_s;
            logic [DATA_WIDTH-1:0] b_o_s;
            logic                  v_o_s;

            sa_os_pe #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH)
            ) u_pe (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .clr_i (start_s),
                .a_i   (a_h_s[gi][gj]),
                .b_i   (b_v_s[gi][gj]),
                .v_i   (v_h_s[gi][gj]),
                .a_o   (a_o_s),
                .b_o   (b_o_s),
                .v_o   (v_o_s),
                .acc_o (acc_s[gi][gj])
            );

            if (gj < N_COLS - 1) begin : g_east
                assign a_h_s[gi][gj+1] = a_o_s;
                assign v_h_s[gi][gj+1] = v_o_s;
            end else begin : g_east_edge
                logic unused_east_s;
                assign unused_east_s = ^{a_o_s, v_o_s};
            end

            if (gi < M_ROWS - 1) begin : g_south
                assign b_v_s[gi+1][gj] = b_o_s;
            end else begin : g_south_edge
                logic unused_south_s;
                assign unused_south_s = ^b_o_s;
            end
        end
    end

    assign in_ready_o  = in_ready_r;
    assign out_data_o  = out_data_r;
    assign out_valid_o = out_valid_r;
    assign out_last_o  = out_last_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;

endmodule

// File: tb/tb_sa_os_stream.sv
// tb_sa_os_stream: directed self-checking bench for sa_os_stream on a 2x2 grid
// (DATA 16, ACC 32, K_MAX 16). Expected values are hand-computed constants.
module tb_sa_os_stream;

    logic             clk_i;
    logic             rst_i;
    logic             start_i;
    logic [4:0]       k_len_i;
    logic [1:0][15:0] a_data_i;
    logic [1:0][15:0] b_data_i;
    logic             a_valid_i;
    logic             b_valid_i;
    logic             in_ready_o;
    logic [31:0]      out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             out_last_o;
    logic             busy_o;
    logic             done_o;

    int n_checks;
    int n_fail;

    logic [31:0] d_v;
    logic        l_v;

    sa_os_stream #(
        .DATA_WIDTH (16),
        .ACC_WIDTH  (32),
        .M_ROWS     (2),
        .N_COLS     (2),
        .K_MAX      (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .k_len_i     (k_len_i),
        .a_data_i    (a_data_i),
        .b_data_i    (b_data_i),
        .a_valid_i   (a_valid_i),
        .b_valid_i   (b_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [4:0] k);
        start_i = 1'b1;
        k_len_i = k;
        tick();
        start_i = 1'b0;
    endtask

    task automatic beat(input logic [15:0] a0, input logic [15:0] a1,
                        input logic [15:0] b0, input logic [15:0] b1);
        a_data_i  = {a1, a0};
        b_data_i  = {b1, b0};
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        tick();
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
    endtask

    // Wait (bounded) for a presented element, record it and complete the handshake.
    task automatic get_elem(output logic [31:0] d, output logic l);
        int n;
        n = 0;
        out_ready_i = 1'b1;
        while (out_valid_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("out_valid_wait", {31'd0, out_valid_o}, 32'd1);
        d = out_data_o;
        l = out_last_o;
        tick();
    endtask

    // Collect all four C elements, then check the done pulse and return to idle.
    task automatic expect_stream(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                                 input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp_a [4];
        logic [31:0] d;
        logic        l;
        exp_a[0] = e0; exp_a[1] = e1; exp_a[2] = e2; exp_a[3] = e3;
        for (int i = 0; i < 4; i++) begin
            get_elem(d, l);
            chk({tag, "_data"}, d, exp_a[i]);
            chk({tag, "_last"}, {31'd0, l}, (i == 3) ? 32'd1 : 32'd0);
        end
        chk({tag, "_done"}, {31'd0, done_o}, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy_o}, 32'd0);
        tick();
        chk({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_i       = 1'b1;
        start_i     = 1'b0;
        k_len_i     = 5'd0;
        a_data_i    = 32'd0;
        b_data_i    = 32'd0;
        a_valid_i   = 1'b0;
        b_valid_i   = 1'b0;
        out_ready_i = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_out_last", {31'd0, out_last_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_out_data", out_data_o, 32'd0);
        rst_i = 1'b0;
        tick();

        // Basic K=1 job: a=[3,4], b=[5,6]
        do_start(5'd1);
        chk("j1_in_ready", {31'd0, in_ready_o}, 32'd1);
        chk("j1_busy", {31'd0, busy_o}, 32'd1);
        beat(16'd3, 16'd4, 16'd5, 16'd6);
        chk("j1_load_exit", {31'd0, in_ready_o}, 32'd0);
        expect_stream("j1", 32'd15, 32'd18, 32'd20, 32'd24);

        // Signed K=2 job; start_i pulsed mid-job must be ignored
        do_start(5'd2);
        start_i = 1'b1;
        beat(-16'sd2, 16'd1, 16'd3, 16'd3);
        start_i = 1'b0;
        beat(-16'sd2, 16'd1, 16'd3, 16'd3);
        expect_stream("j2", 32'hFFFF_FFF4, 32'hFFFF_FFF4, 32'd6, 32'd6);

        // Gapped K=1 job: bubble cycle with junk data, valids after LOAD ignored
        do_start(5'd1);
        a_data_i  = {16'd100, 16'd100};
        b_data_i  = {16'd100, 16'd100};
        a_valid_i = 1'b0;
        b_valid_i = 1'b1;
        tick();
        chk("gap_in_ready", {31'd0, in_ready_o}, 32'd1);
        b_valid_i = 1'b0;
        tick();
        chk("gap_in_ready2", {31'd0, in_ready_o}, 32'd1);
        beat(16'd3, 16'd4, 16'd5, 16'd6);
        a_data_i  = {16'd100, 16'd100};
        b_data_i  = {16'd100, 16'd100};
        a_valid_i = 1'b1;
        b_valid_i = 1'b1;
        tick();
        tick();
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        expect_stream("gap", 32'd15, 32'd18, 32'd20, 32'd24);

        // Back-pressure: stall 3 cycles on element 18
        do_start(5'd1);
        beat(16'd3, 16'd4, 16'd5, 16'd6);
        get_elem(d_v, l_v);
        chk("bp_first", d_v, 32'd15);
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_data", out_data_o, 32'd18);
            chk("bp_hold_valid", {31'd0, out_valid_o}, 32'd1);
            tick();
        end
        chk("bp_hold_last", {31'd0, out_last_o}, 32'd0);
        get_elem(d_v, l_v);
        chk("bp_e18", d_v, 32'd18);
        get_elem(d_v, l_v);
        chk("bp_e20", d_v, 32'd20);
        get_elem(d_v, l_v);
        chk("bp_e24", d_v, 32'd24);
        chk("bp_e24_last", {31'd0, l_v}, 32'd1);
        chk("bp_done", {31'd0, done_o}, 32'd1);
        tick();

        // Large operands, K=4: wrap or saturate
        do_start(5'd4);
        for (int i = 0; i < 4; i++) begin
            beat(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        end
`ifdef SA_OS_SAT_EN
        expect_stream("big", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
`else
        expect_stream("big", 32'hFFFC_0004, 32'hFFFC_0004, 32'hFFFC_0004, 32'hFFFC_0004);
`endif

        // k_len above K_MAX clamps to 16 beats
        do_start(5'd31);
        for (int i = 0; i < 15; i++) begin
            beat(16'd1, 16'd1, 16'd1, 16'd1);
        end
        chk("clamp_still_load", {31'd0, in_ready_o}, 32'd1);
        beat(16'd1, 16'd1, 16'd1, 16'd1);
        chk("clamp_load_exit", {31'd0, in_ready_o}, 32'd0);
        expect_stream("clamp", 32'd16, 32'd16, 32'd16, 32'd16);

        // K=0 goes straight to STREAM with cleared accumulators
        do_start(5'd0);
        chk("k0_in_ready", {31'd0, in_ready_o}, 32'd0);
        chk("k0_busy", {31'd0, busy_o}, 32'd1);
        expect_stream("k0", 32'd0, 32'd0, 32'd0, 32'd0);

        // Reset mid-STREAM abandons the job
        do_start(5'd1);
        beat(16'd3, 16'd4, 16'd5, 16'd6);
        get_elem(d_v, l_v);
        chk("mid_first", d_v, 32'd15);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("mid_rst_data", out_data_o, 32'd0);
        chk("mid_rst_last", {31'd0, out_last_o}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready_o}, 32'd0);
        chk("mid_rst_done", {31'd0, done_o}, 32'd0);
        tick();
        chk("mid_rst_done2", {31'd0, done_o}, 32'd0);
        do_start(5'd1);
        beat(16'd3, 16'd4, 16'd5, 16'd6);
        expect_stream("post_rst", 32'd15, 32'd18, 32'd20, 32'd24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
